// File: rtl/register_rename.sv
// register_rename
//   Rename stage of an out-of-order pipeline. It maps 32 architectural
//   registers to 256 physical tags through a register alias table (RAT).
//   It also keeps a circular free list of tags that can be allocated.
//   Tags are handed out in FIFO order from the head of the free list.
//   Tags returned at retire are pushed at the tail.
//
// Ports
//   clk          : single clock, all state changes on its rising edge
//   reset        : synchronous, active-low reset
//   valid_in     : a decoded instruction is presented
//   rs1, rs2, rd : architectural source and destination registers
//   rd_write     : the instruction writes rd
//   stall_in     : the register-file read stage cannot accept
//   ready_out    : rename accepts an instruction this cycle (combinational)
//   free_valid   : a physical tag is returned at retire
//   free_phy     : the returned physical tag
//   Operand1_phy : renamed rs1 tag
//   Operand2_phy : renamed rs2 tag
//   Rd_phy       : newly allocated destination tag (0 if none)
//   Old_Rd_phy   : previous mapping of rd (0 if none)
//   valid_out    : the tag outputs are valid for the register-file stage
//
// Optional feature (macro RENAME_STATS_EN)
//   free_count   : current number of free tags
//   stall_cycles : number of cycles an instruction waited on an empty free
//                  list; saturates at 0xFFFF
module register_rename (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  input  logic       rd_write,
  input  logic       stall_in,
  output logic       ready_out,
  input  logic       free_valid,
  input  logic [7:0] free_phy,
  output logic [7:0] Operand1_phy,
  output logic [7:0] Operand2_phy,
  output logic [7:0] Rd_phy,
  output logic [7:0] Old_Rd_phy,
  output logic       valid_out
`ifdef RENAME_STATS_EN
  ,
  output logic [8:0]  free_count,
  output logic [15:0] stall_cycles
`endif
);

  // Tags 0..31 start out mapped by the RAT; tags 32..255 start out free.
  localparam logic [8:0] FREE_MAX = 9'd224;

  logic [7:0] rat       [32];
  logic [7:0] free_list [256];
  logic [7:0] head;
  logic [7:0] tail;
  logic [8:0] count;

  logic accept;
  logic do_pop;
  logic do_push;

  // An instruction that does not write is still held back on an empty list.
  // This keeps the accept rule independent of the instruction type.
  always_comb begin
    ready_out = !stall_in && (count != 9'd0);
    accept    = valid_in && ready_out;
    do_pop    = accept && rd_write && (rd != 5'd0);
    do_push   = free_valid && (free_phy != 8'd0) && (count < FREE_MAX);
  end

  // The head and tail pointers wrap naturally at 256.
  // The count never reaches 256, so head == tail only when the list is
  // empty. A same-cycle pop and push therefore never use the same slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= 8'd0;
      tail  <= 8'd224;
      count <= FREE_MAX;
    end else begin
      if (do_pop)
        head <= head + 8'd1;
      if (do_push)
        tail <= tail + 8'd1;
      case ({do_pop, do_push})
        2'b10:   count <= count - 9'd1;
        2'b01:   count <= count + 9'd1;
        default: count <= count;
      endcase
    end
  end

  // A pushed tag lands in the array at the clock edge.
  // So it cannot be popped in the same cycle it is freed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++)
        free_list[i] <= (i < 224) ? 8'(i + 32) : 8'd0;
    end else if (do_push) begin
      free_list[tail] <= free_phy;
    end
  end

  // RAT[0] is only ever written by reset, because do_pop excludes rd == 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        rat[i] <= 8'(i);
    end else if (do_pop) begin
      rat[rd] <= free_list[head];
    end
  end

  // The operands read the RAT before this cycle's update.
  // So an instruction that overwrites its own source sees the old mapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      Operand1_phy <= 8'd0;
      Operand2_phy <= 8'd0;
      Rd_phy       <= 8'd0;
      Old_Rd_phy   <= 8'd0;
      valid_out    <= 1'b0;
    end else if (accept) begin
      Operand1_phy <= rat[rs1];
      Operand2_phy <= rat[rs2];
      valid_out    <= 1'b1;
      if (do_pop) begin
        Rd_phy     <= free_list[head];
        Old_Rd_phy <= rat[rd];
      end else begin
        Rd_phy     <= 8'd0;
        Old_Rd_phy <= 8'd0;
      end
    end else if (!stall_in) begin
      valid_out <= 1'b0;
    end
  end

`ifdef RENAME_STATS_EN
  assign free_count = count;

  // Counts cycles where an instruction is present but the free list is empty.
  always_ff @(posedge clk) begin
    if (!reset)
      stall_cycles <= 16'd0;
    else if (valid_in && (count == 9'd0) && (stall_cycles != 16'hFFFF))
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: doc/register_rename.md
REGISTER_RENAME -- requirements
Module: register_rename

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 SHALL have port valid_in, input, 1, decoded instruction present.
REQ-004 SHALL have ports rs1/rs2/rd, input, 5 each, architectural source and destination registers.
REQ-005 SHALL have port rd_write, input, 1, instruction writes rd.
REQ-006 SHALL have port stall_in, input, 1, downstream (register-file read stage) cannot accept.
REQ-007 SHALL have port ready_out, output, 1, rename accepts this cycle.
REQ-008 SHALL have ports free_valid, input, 1, and free_phy, input, 8, physical register returned at retire.
REQ-009 SHALL have ports Operand1_phy/Operand2_phy/Rd_phy/Old_Rd_phy, output reg, 8 each, renamed tags.
REQ-010 SHALL have port valid_out, output reg, 1, tags valid for the register-file stage.

Function
REQ-011 SHALL hold a 32x8 RAT and a 256-entry circular free-list FIFO with 8-bit head/tail pointers and a 9-bit count.
REQ-012 SHALL set ready_out = !stall_in && (count != 0), combinationally.
REQ-013 SHALL define accept = valid_in && ready_out.
REQ-014 On accept, SHALL register Operand1_phy = RAT[rs1] and Operand2_phy = RAT[rs2], read before this cycle's RAT update, so rd==rs1 yields the old mapping.
REQ-015 On accept with rd_write=1 and rd!=0, SHALL pop the head into Rd_phy, set Old_Rd_phy = RAT[rd], write RAT[rd] = popped tag, and advance head.
REQ-016 On accept with rd_write=0 or rd=0, SHALL set Rd_phy = 0 and Old_Rd_phy = 0, without popping or updating the RAT.
REQ-017 SHALL keep RAT[0] = 0 at all times.
REQ-018 SHALL set valid_out=1 on accept; with stall_in=1, SHALL hold all outputs unchanged; with no accept and stall_in=0, SHALL set valid_out=0 and leave the tags unchanged.
REQ-019 Latency SHALL be 1 cycle from accept to valid_out.
REQ-020 On free_valid with free_phy!=0 and count<224, SHALL push free_phy at the tail and advance the tail, wrapping 255->0.
REQ-021 SHALL ignore a free with free_phy=0 or count=224.
REQ-022 On a simultaneous pop and push, SHALL leave count unchanged, with both pointers advancing.
REQ-023 A tag pushed in cycle N SHALL NOT be allocatable before cycle N+1 (no empty-list bypass).
REQ-024 With count=0, SHALL deassert ready_out and allow no RAT change, even for non-writing instructions.

Reset
REQ-025 On reset=0 at a clk edge, SHALL set RAT[i]=i for i=0..31, fill free-list entries 0..223 with 32..255, set head=0, tail=224, count=224, valid_out=0, and all tag outputs to 0.
REQ-026 Reset SHALL override any in-flight accept or free in the same cycle.

Configuration
REQ-027 With RENAME_STATS_EN defined, SHALL add output free_count (9 bits, equal to count) and output stall_cycles (16 bits), which increments each cycle valid_in=1 and count=0, saturates at 0xFFFF, and resets to 0.
REQ-028 Without RENAME_STATS_EN, SHALL have neither port nor its logic, with all other behaviour identical.

Verification
REQ-029 Reset, then rename add x5,x1,x2 -> next cycle Operand1_phy=1, Operand2_phy=2, Rd_phy=32, Old_Rd_phy=5, valid_out=1.
REQ-030 Back-to-back x5=x5+x5 twice -> second output Operand1_phy=32, Operand2_phy=32, Rd_phy=33, Old_Rd_phy=32.
REQ-031 224 consecutive writing renames -> ready_out=0 after the 224th; then free_phy=40 -> ready_out=1 the next cycle, and the next rename gets Rd_phy=40.
REQ-032 stall_in=1 for 3 cycles with valid_out=1 -> outputs held; RAT and count unchanged; no allocation.
REQ-033 rd=0 with rd_write=1 -> Rd_phy=0, count unchanged; simultaneous alloc and free_phy=7 -> count unchanged, tail advanced.
REQ-034 reset=0 asserted mid-sequence, with accept and free high -> next cycle count=224, valid_out=0, RAT identity.
